// File: rtl/hd_int_ctrl.sv
// hd_int_ctrl: priority interrupt controller in front of the hardwired CPU sequencer.
// Optional feature: define HD_INT_NEST_EN for nested (preemptive) service; default is single-level.

// Per-line 2-flop synchroniser plus previous-value flop; flags a sampled 0->1.
module hd_int_sync (
    input  logic T3,
    input  logic CLR,
    input  logic irq,
    output logic rise
);
    logic s1, s2, prev;

    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= irq;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;
endmodule

module hd_int_ctrl #(
    parameter int         NREQ     = 4,
    parameter logic [7:0] VEC_BASE = 8'hE0
) (
    input  logic            T3,
    input  logic            CLR,
    input  logic [NREQ-1:0] IRQ,
    input  logic            MASK_WE,
    input  logic [NREQ-1:0] MASK_D,
    input  logic            EI_SET,
    input  logic            EI_CLR,
    input  logic            INTA,
    input  logic            IRET_DONE,
    output logic            INTR,
    output logic [7:0]      VEC,
    output logic [2:0]      ACT_ID,
    output logic            IEN,
    output logic [NREQ-1:0] PEND
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SERV = 1'b1;

    logic [0:0]      state, state_n;
    logic [NREQ-1:0] mask, isr, rise;
    logic [NREQ-1:0] mask_n, pend_n, isr_n;
    logic            ien_n, intr_n;
    logic [2:0]      act_n;
    logic [7:0]      vec_n;
    logic [3:0]      win, top, win_n, nxt;
    logic            accept, retire;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        hd_int_sync u_sync (
            .T3   (T3),
            .CLR  (CLR),
            .irq  (IRQ[i]),
            .rise (rise[i])
        );
    end

    // {found, index} of the lowest set bit; lowest index is highest priority.
    function automatic logic [3:0] first_set(input logic [NREQ-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (v[i]) r = {1'b1, 3'(i)};
        return r;
    endfunction

    function automatic logic [7:0] vec_of(input logic [2:0] id);
        return VEC_BASE + {3'b000, id, 2'b00};
    endfunction

    assign win    = first_set(PEND & ~mask);
    assign top    = first_set(isr);
    // INTR already encodes IEN, state and (nested) priority against the active level.
    assign accept = INTA & INTR & win[3];
    assign retire = IRET_DONE & top[3];

    always_comb begin
        state_n = state;
        pend_n  = PEND;
        isr_n   = isr;
        act_n   = ACT_ID;
        vec_n   = VEC;
        ien_n   = IEN;
        nxt     = '0;
        mask_n  = MASK_WE ? MASK_D : mask;

        if (accept) begin
            for (int i = 0; i < NREQ; i++) begin
                if (3'(i) == win[2:0]) begin
                    pend_n[i] = 1'b0;
                    isr_n[i]  = 1'b1;
                end
            end
            act_n   = win[2:0];
            vec_n   = vec_of(win[2:0]);
            ien_n   = 1'b0;
            state_n = S_SERV;
        end else if (retire) begin
            for (int i = 0; i < NREQ; i++)
                if (3'(i) == top[2:0]) isr_n[i] = 1'b0;
            ien_n = 1'b1;
            nxt   = first_set(isr_n);
            if (nxt[3]) begin
                act_n = nxt[2:0];
                vec_n = vec_of(nxt[2:0]);
            end else begin
                state_n = S_IDLE;
            end
        end

        // A fresh edge on the line being acknowledged survives as a new event.
        pend_n = pend_n | rise;

        if (EI_CLR)      ien_n = 1'b0;
        else if (EI_SET) ien_n = 1'b1;

        win_n = first_set(pend_n & ~mask_n);
`ifdef HD_INT_NEST_EN
        begin
            logic [3:0] top_n;
            top_n  = first_set(isr_n);
            intr_n = ien_n & win_n[3] & (~top_n[3] | (win_n[2:0] < top_n[2:0]));
        end
`else
        intr_n = ien_n & win_n[3] & (state_n == S_IDLE);
`endif
    end

    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            state  <= S_IDLE;
            PEND   <= '0;
            mask   <= '0;
            isr    <= '0;
            IEN    <= 1'b1;
            INTR   <= 1'b0;
            VEC    <= 8'h00;
            ACT_ID <= 3'd0;
        end else begin
            state  <= state_n;
            PEND   <= pend_n;
            mask   <= mask_n;
            isr    <= isr_n;
            IEN    <= ien_n;
            INTR   <= intr_n;
            VEC    <= vec_n;
            ACT_ID <= act_n;
        end
    end
endmodule

// File: tb/tb_hd_int_ctrl.sv
// Directed + randomized bench for hd_int_ctrl against a queue-based behavioural model.
module tb_hd_int_ctrl;
    localparam int         NREQ = 4;
    localparam logic [7:0] VB   = 8'hE0;
    localparam logic [7:0] VB2  = 8'hFC;
`ifdef HD_INT_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic            T3 = 1'b1;
    logic            CLR = 1'b0;
    logic [NREQ-1:0] IRQ = '0, MASK_D = '0;
    logic            MASK_WE = 0, EI_SET = 0, EI_CLR = 0, INTA = 0, IRET_DONE = 0;
    logic            INTR, IEN, INTR2, IEN2;
    logic [7:0]      VEC, VEC2;
    logic [2:0]      ACT_ID, ACT2;
    logic [NREQ-1:0] PEND, PEND2;

    hd_int_ctrl #(.NREQ(NREQ), .VEC_BASE(VB)) dut (
        .T3(T3), .CLR(CLR), .IRQ(IRQ), .MASK_WE(MASK_WE), .MASK_D(MASK_D),
        .EI_SET(EI_SET), .EI_CLR(EI_CLR), .INTA(INTA), .IRET_DONE(IRET_DONE),
        .INTR(INTR), .VEC(VEC), .ACT_ID(ACT_ID), .IEN(IEN), .PEND(PEND));

    hd_int_ctrl #(.NREQ(NREQ), .VEC_BASE(VB2)) dut2 (
        .T3(T3), .CLR(CLR), .IRQ(IRQ), .MASK_WE(MASK_WE), .MASK_D(MASK_D),
        .EI_SET(EI_SET), .EI_CLR(EI_CLR), .INTA(INTA), .IRET_DONE(IRET_DONE),
        .INTR(INTR2), .VEC(VEC2), .ACT_ID(ACT2), .IEN(IEN2), .PEND(PEND2));

    always #5 T3 = ~T3;

    int nchk = 0, nerr = 0;

    // Behavioural model: pending/mask vectors, a list of in-service ids, IRQ sample history.
    logic [NREQ-1:0] m_pend, m_mask;
    logic            m_ien, m_intr, m_vv;
    int              m_act;
    int              svc[$];
    logic [NREQ-1:0] hist[$];

    function automatic logic [7:0] vec_of(input logic [7:0] b, input int id);
        return 8'((int'(b) + 4 * id) % 256);
    endfunction

    function automatic int winner();
        for (int i = 0; i < NREQ; i++)
            if (m_pend[i] && !m_mask[i]) return i;
        return -1;
    endfunction

    function automatic int svc_min();
        int m = NREQ;
        foreach (svc[k]) if (svc[k] < m) m = svc[k];
        return m;
    endfunction

    task automatic mreset();
        m_pend = '0; m_mask = '0; m_ien = 1'b1; m_intr = 1'b0; m_vv = 1'b0; m_act = 0;
        svc.delete();
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back('0);
    endtask

    // Advance the model over one T3 fall using the inputs currently applied.
    task automatic mstep();
        logic [NREQ-1:0] ev;
        int w, m;
        hist.push_front(IRQ);
        ev = hist[2] & ~hist[3];
        void'(hist.pop_back());
        w = winner();
        if (INTA && m_intr && w >= 0) begin
            m_pend[w] = 1'b0;
            svc.push_back(w);
            m_act = w; m_vv = 1'b1; m_ien = 1'b0;
        end else if (IRET_DONE && svc.size() > 0) begin
            m = svc_min();
            foreach (svc[k]) if (svc[k] == m) begin svc.delete(k); break; end
            m_ien = 1'b1;
            if (svc.size() > 0) m_act = svc_min();
        end
        m_pend = m_pend | ev;
        if (EI_CLR)      m_ien = 1'b0;
        else if (EI_SET) m_ien = 1'b1;
        if (MASK_WE) m_mask = MASK_D;
        w = winner();
        m_intr = m_ien && (w >= 0) && (svc.size() == 0 || (NEST && w < svc_min()));
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("INTR",  32'(INTR),   32'(m_intr));
        chk("IEN",   32'(IEN),    32'(m_ien));
        chk("PEND",  32'(PEND),   32'(m_pend));
        chk("ACT",   32'(ACT_ID), 32'(m_act));
        chk("VEC",   32'(VEC),    32'(m_vv ? vec_of(VB, m_act) : 8'h00));
        chk("INTR2", 32'(INTR2),  32'(m_intr));
        chk("IEN2",  32'(IEN2),   32'(m_ien));
        chk("PEND2", 32'(PEND2),  32'(m_pend));
        chk("ACT2",  32'(ACT2),   32'(m_act));
        chk("VEC2",  32'(VEC2),   32'(m_vv ? vec_of(VB2, m_act) : 8'h00));
    endtask

    // One T3 fall with the current inputs, checked at the following rising edge.
    task automatic step();
        mstep();
        @(negedge T3);
        @(posedge T3);
        check_model();
        INTA = 0; IRET_DONE = 0; EI_SET = 0; EI_CLR = 0; MASK_WE = 0;
    endtask

    initial begin
        mreset();
        @(posedge T3);
        chk("rst_INTR", 32'(INTR), 32'd0);
        chk("rst_IEN",  32'(IEN),  32'd1);
        chk("rst_PEND", 32'(PEND), 32'd0);
        chk("rst_VEC",  32'(VEC),  32'h00);
        chk("rst_ACT",  32'(ACT_ID), 32'd0);
        CLR = 1'b1;

        // Priority: lines 2 and 1 rise together.
        IRQ = 4'b0110;
        repeat (3) step();
        chk("pri_PEND", 32'(PEND), 32'h6);
        chk("pri_INTR", 32'(INTR), 32'd1);
        INTA = 1; step();
        chk("pri_ACT1", 32'(ACT_ID), 32'd1);
        chk("pri_VEC1", 32'(VEC),    32'hE4);
        chk("wrap_VEC", 32'(VEC2),   32'h00);
        chk("pri_PND1", 32'(PEND),   32'h4);
        chk("pri_IEN0", 32'(IEN),    32'd0);
        IRET_DONE = 1; step();
        chk("pri_INTR2", 32'(INTR), 32'd1);
        INTA = 1; step();
        chk("pri_ACT2", 32'(ACT_ID), 32'd2);
        chk("pri_VEC2", 32'(VEC),    32'hE8);

        // Reset mid-service with PEND=0110.
        IRQ = 4'b0000; repeat (2) step();
        IRQ = 4'b0110; repeat (3) step();
        chk("pre_rst_PEND", 32'(PEND), 32'h6);
        #1 CLR = 1'b0; IRQ = 4'b0000;
        #1;
        chk("mid_rst_IEN",  32'(IEN),  32'd1);
        chk("mid_rst_PEND", 32'(PEND), 32'd0);
        chk("mid_rst_INTR", 32'(INTR), 32'd0);
        chk("mid_rst_VEC",  32'(VEC),  32'h00);
        mreset();
        #1 CLR = 1'b1;
        step();

        // Masking and enable.
        MASK_WE = 1; MASK_D = 4'b0001; step();
        IRQ = 4'b0001; repeat (3) step();
        chk("msk_INTR", 32'(INTR),    32'd0);
        chk("msk_PEND", 32'(PEND[0]), 32'd1);
        EI_CLR = 1; step();
        MASK_WE = 1; MASK_D = 4'b0000; step();
        chk("dis_INTR", 32'(INTR), 32'd0);
        EI_SET = 1; step();
        chk("en_INTR", 32'(INTR), 32'd1);
        INTA = 1; step();
        chk("msk_VEC", 32'(VEC), 32'hE0);
        IRET_DONE = 1; IRQ = 4'b0000; step();

        // Ignored handshakes.
        INTA = 1; step();
        chk("ign_PEND", 32'(PEND), 32'd0);
        chk("ign_IEN",  32'(IEN),  32'd1);
        chk("ign_VEC",  32'(VEC),  32'hE0);
        IRET_DONE = 1; step();
        chk("ign2_IEN", 32'(IEN), 32'd1);
        chk("ign2_VEC", 32'(VEC), 32'hE0);
        EI_SET = 1; EI_CLR = 1; step();
        chk("eiboth_IEN", 32'(IEN), 32'd0);
        EI_SET = 1; step();

        // Same-line re-request landing on the INTA edge.
        IRQ = 4'b1000; repeat (3) step();
        IRQ = 4'b0000; step();
        IRQ = 4'b1000; step();
        step();
        INTA = 1; step();
        chk("same_ACT",  32'(ACT_ID),  32'd3);
        chk("same_PEND", 32'(PEND[3]), 32'd1);
        IRET_DONE = 1; step();
        chk("same_INTR", 32'(INTR), 32'd1);
        INTA = 1; step();
        IRET_DONE = 1; IRQ = 4'b0000; step();

        // Nesting: serve 2, re-enable, then request 0 arrives.
        IRQ = 4'b0100; repeat (3) step();
        INTA = 1; step();
        EI_SET = 1; step();
        IRQ = 4'b0101; repeat (3) step();
        if (NEST) begin
            chk("nest_INTR", 32'(INTR), 32'd1);
            INTA = 1; step();
            chk("nest_VEC0", 32'(VEC), 32'hE0);
            IRET_DONE = 1; step();
            chk("nest_ACT2", 32'(ACT_ID), 32'd2);
            chk("nest_VEC2", 32'(VEC),    32'hE8);
            IRET_DONE = 1; step();
        end else begin
            chk("flat_INTR", 32'(INTR), 32'd0);
            INTA = 1; step();
            chk("flat_VEC", 32'(VEC), 32'hE8);
            IRET_DONE = 1; step();
            chk("flat_INTR2", 32'(INTR), 32'd1);
            INTA = 1; step();
            IRET_DONE = 1; step();
        end
        IRQ = 4'b0000; repeat (2) step();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) IRQ[i] = IRQ[i] ^ ($urandom_range(7) == 0);
            MASK_WE   = ($urandom_range(9) == 0);
            MASK_D    = 4'($urandom);
            EI_SET    = ($urandom_range(11) == 0);
            EI_CLR    = ($urandom_range(15) == 0);
            INTA      = ($urandom_range(2) == 0);
            IRET_DONE = ($urandom_range(4) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
